// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding instruction-memory
// request, and registers the fetched word into the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] f_nextpc,
  input  logic        f_indelayslot,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] f_nowpc,
  output logic        f_stall_req,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] ftod_pc,
  output logic [31:0] ftod_instr,
  output logic        ftod_addr_err_if,
  output logic        ftod_in_delay_slot,
  output logic        ftod_is_instr
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic              cancel_q, cancel_d;

  logic [XLEN-1:0]   ftod_pc_d, ftod_instr_d;
  logic              ftod_addr_err_if_d, ftod_in_delay_slot_d, ftod_is_instr_d;

  logic              aerr, accepted, in_wait, resp, ready, advance;
  logic [XLEN-1:0]   word;

  // Memory-side handshake and readiness; depends only on state and memory inputs.
  always_comb begin
    aerr        = (state_q == S_REQ) && !cancel_q && (pc_q[1:0] != 2'b00);
    inst_req    = !rst && (state_q == S_REQ) && (!aerr || cancel_q);
    inst_addr   = cancel_q ? req_addr_q : pc_q;
    accepted    = inst_req && inst_addr_ok;
    // addr_ok and data_ok in the same REQ cycle behave like WAIT + data_ok
    in_wait     = (state_q == S_WAIT) || accepted;
    resp        = in_wait && inst_data_ok;
    ready       = (state_q == S_HOLD) || (resp && !cancel_q) || aerr;
    word        = (state_q == S_HOLD) ? buf_q : (aerr ? XLEN'(0) : inst_rdata);
    f_stall_req = !ready;
    advance     = ready && !stall && !flush;
    f_nowpc     = pc_q;
  end

  // Next-state, PC and IF/ID update.
  always_comb begin
    state_d              = state_q;
    pc_d                 = pc_q;
    buf_d                = buf_q;
    cancel_d             = cancel_q;
    req_addr_d           = cancel_q ? req_addr_q : pc_q;
    ftod_pc_d            = ftod_pc;
    ftod_instr_d         = ftod_instr;
    ftod_addr_err_if_d   = ftod_addr_err_if;
    ftod_in_delay_slot_d = ftod_in_delay_slot;
    ftod_is_instr_d      = ftod_is_instr;

    if (flush) begin
      ftod_pc_d            = '0;
      ftod_instr_d         = '0;
      ftod_addr_err_if_d   = 1'b0;
      ftod_in_delay_slot_d = 1'b0;
      ftod_is_instr_d      = 1'b0;
      pc_d                 = f_nextpc;
      if (state_q == S_HOLD) begin
        state_d  = S_REQ;
        cancel_d = 1'b0;
      end else if (in_wait) begin
        // a response landing in the flush cycle is simply dropped
        state_d  = inst_data_ok ? S_REQ : S_WAIT;
        cancel_d = !inst_data_ok;
      end else if (inst_req) begin
        cancel_d = 1'b1;
      end
    end else if (advance) begin
      ftod_pc_d            = pc_q;
      ftod_instr_d         = word;
      ftod_addr_err_if_d   = aerr;
      ftod_in_delay_slot_d = f_indelayslot;
      ftod_is_instr_d      = 1'b1;
      pc_d                 = f_nextpc;
      state_d              = S_REQ;
    end else if (resp && cancel_q) begin
      state_d  = S_REQ;
      cancel_d = 1'b0;
    end else if (resp) begin
      buf_d   = inst_rdata;
      state_d = S_HOLD;
    end else if (accepted) begin
      state_d = S_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_REQ;
      pc_q               <= RESET_PC;
      buf_q              <= '0;
      cancel_q           <= 1'b0;
      req_addr_q         <= RESET_PC;
      ftod_pc            <= '0;
      ftod_instr         <= '0;
      ftod_addr_err_if   <= 1'b0;
      ftod_in_delay_slot <= 1'b0;
      ftod_is_instr      <= 1'b0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      buf_q              <= buf_d;
      cancel_q           <= cancel_d;
      req_addr_q         <= req_addr_d;
      ftod_pc            <= ftod_pc_d;
      ftod_instr         <= ftod_instr_d;
      ftod_addr_err_if   <= ftod_addr_err_if_d;
      ftod_in_delay_slot <= ftod_in_delay_slot_d;
      ftod_is_instr      <= ftod_is_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: bench drives the memory handshake by hand.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_nextpc;
  logic        f_indelayslot;
  logic        stall;
  logic        flush;
  logic [31:0] f_nowpc;
  logic        f_stall_req;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] ftod_pc;
  logic [31:0] ftod_instr;
  logic        ftod_addr_err_if;
  logic        ftod_in_delay_slot;
  logic        ftod_is_instr;

  int checks   = 0;
  int failures = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .f_nextpc(f_nextpc), .f_indelayslot(f_indelayslot),
    .stall(stall), .flush(flush), .f_nowpc(f_nowpc), .f_stall_req(f_stall_req),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .ftod_pc(ftod_pc),
    .ftod_instr(ftod_instr), .ftod_addr_err_if(ftod_addr_err_if),
    .ftod_in_delay_slot(ftod_in_delay_slot), .ftod_is_instr(ftod_is_instr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; f_nextpc = '0; f_indelayslot = 1'b0; stall = 1'b0; flush = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    step(); step();
    checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", inst_req); end
    checks++; if (ftod_is_instr !== 1'b0) begin failures++; $display("FAIL reset_is_instr got=%b exp=0", ftod_is_instr); end
    checks++; if (ftod_pc !== 32'h0) begin failures++; $display("FAIL reset_ftod_pc got=%h exp=0", ftod_pc); end
    checks++; if (f_nowpc !== 32'hBFC00000) begin failures++; $display("FAIL reset_pc got=%h exp=bfc00000", f_nowpc); end
  endtask

  task automatic test_first_fetch();
    rst = 1'b0; f_nextpc = 32'hBFC00004; inst_addr_ok = 1'b1;
    #1;
    checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", inst_req); end
    checks++; if (inst_addr !== 32'hBFC00000) begin failures++; $display("FAIL first_addr got=%h exp=bfc00000", inst_addr); end
    checks++; if (f_stall_req !== 1'b1) begin failures++; $display("FAIL first_stallreq got=%b exp=1", f_stall_req); end
    step();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h24010001;
    #1;
    checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL wait_req got=%b exp=0", inst_req); end
    step();
    inst_data_ok = 1'b0;
    checks++; if (ftod_pc !== 32'hBFC00000) begin failures++; $display("FAIL first_ftod_pc got=%h exp=bfc00000", ftod_pc); end
    checks++; if (ftod_instr !== 32'h24010001) begin failures++; $display("FAIL first_instr got=%h exp=24010001", ftod_instr); end
    checks++; if (ftod_is_instr !== 1'b1) begin failures++; $display("FAIL first_is_instr got=%b exp=1", ftod_is_instr); end
    checks++; if (f_nowpc !== 32'hBFC00004) begin failures++; $display("FAIL first_nextpc got=%h exp=bfc00004", f_nowpc); end
  endtask

  task automatic test_stall_return();
    inst_addr_ok = 1'b1; f_nextpc = 32'hBFC00008;
    step();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8C220004; stall = 1'b1;
    #1;
    checks++; if (f_stall_req !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", f_stall_req); end
    step();
    inst_data_ok = 1'b0; inst_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL hold_req[%0d] got=%b exp=0", i, inst_req); end
      checks++; if (f_stall_req !== 1'b0) begin failures++; $display("FAIL hold_stallreq[%0d] got=%b exp=0", i, f_stall_req); end
      checks++; if (ftod_instr !== 32'h24010001) begin failures++; $display("FAIL hold_instr[%0d] got=%h exp=24010001", i, ftod_instr); end
      checks++; if (f_nowpc !== 32'hBFC00004) begin failures++; $display("FAIL hold_pc[%0d] got=%h exp=bfc00004", i, f_nowpc); end
      step();
    end
    stall = 1'b0;
    step();
    checks++; if (ftod_instr !== 32'h8C220004) begin failures++; $display("FAIL unstall_instr got=%h exp=8c220004", ftod_instr); end
    checks++; if (ftod_pc !== 32'hBFC00004) begin failures++; $display("FAIL unstall_pc got=%h exp=bfc00004", ftod_pc); end
    checks++; if (f_nowpc !== 32'hBFC00008) begin failures++; $display("FAIL unstall_nextpc got=%h exp=bfc00008", f_nowpc); end
  endtask

  task automatic test_flush_wait();
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0; flush = 1'b1; f_nextpc = 32'hBFC00380;
    step();
    flush = 1'b0; f_nextpc = 32'hBFC00384;
    #1;
    checks++; if (ftod_is_instr !== 1'b0) begin failures++; $display("FAIL fw_bubble got=%b exp=0", ftod_is_instr); end
    checks++; if (ftod_instr !== 32'h0) begin failures++; $display("FAIL fw_bubble_instr got=%h exp=0", ftod_instr); end
    checks++; if (f_nowpc !== 32'hBFC00380) begin failures++; $display("FAIL fw_pc got=%h exp=bfc00380", f_nowpc); end
    checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL fw_req got=%b exp=0", inst_req); end
    step();
    inst_data_ok = 1'b1; inst_rdata = 32'h12345678;
    #1;
    checks++; if (f_stall_req !== 1'b1) begin failures++; $display("FAIL fw_drop_ready got=%b exp=1", f_stall_req); end
    step();
    inst_data_ok = 1'b0;
    #1;
    checks++; if (ftod_instr === 32'h12345678) begin failures++; $display("FAIL fw_leak got=%h exp=00000000", ftod_instr); end
    checks++; if (ftod_is_instr !== 1'b0) begin failures++; $display("FAIL fw_still_bubble got=%b exp=0", ftod_is_instr); end
    checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL fw_newreq got=%b exp=1", inst_req); end
    checks++; if (inst_addr !== 32'hBFC00380) begin failures++; $display("FAIL fw_newaddr got=%h exp=bfc00380", inst_addr); end
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h00000021;
    step();
    inst_data_ok = 1'b0;
    checks++; if (ftod_pc !== 32'hBFC00380) begin failures++; $display("FAIL fw_done_pc got=%h exp=bfc00380", ftod_pc); end
    checks++; if (ftod_instr !== 32'h00000021) begin failures++; $display("FAIL fw_done_instr got=%h exp=00000021", ftod_instr); end
  endtask

  task automatic test_flush_req();
    #1;
    checks++; if (inst_addr !== 32'hBFC00384) begin failures++; $display("FAIL fr_addr0 got=%h exp=bfc00384", inst_addr); end
    flush = 1'b1; f_nextpc = 32'hBFC00500;
    step();
    flush = 1'b0; f_nextpc = 32'hBFC00504;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL fr_req[%0d] got=%b exp=1", i, inst_req); end
      checks++; if (inst_addr !== 32'hBFC00384) begin failures++; $display("FAIL fr_oldaddr[%0d] got=%h exp=bfc00384", i, inst_addr); end
      checks++; if (f_nowpc !== 32'hBFC00500) begin failures++; $display("FAIL fr_pc[%0d] got=%h exp=bfc00500", i, f_nowpc); end
      step();
    end
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hAAAAAAAA;
    #1;
    checks++; if (f_stall_req !== 1'b1) begin failures++; $display("FAIL fr_drop_ready got=%b exp=1", f_stall_req); end
    step();
    inst_data_ok = 1'b0;
    #1;
    checks++; if (inst_addr !== 32'hBFC00500) begin failures++; $display("FAIL fr_newaddr got=%h exp=bfc00500", inst_addr); end
    checks++; if (ftod_is_instr !== 1'b0) begin failures++; $display("FAIL fr_bubble got=%b exp=0", ftod_is_instr); end
    f_nextpc = 32'hBFC00002; inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3C1DBFC0;
    step();
    inst_data_ok = 1'b0;
    checks++; if (ftod_instr !== 32'h3C1DBFC0) begin failures++; $display("FAIL fr_done_instr got=%h exp=3c1dbfc0", ftod_instr); end
    checks++; if (ftod_pc !== 32'hBFC00500) begin failures++; $display("FAIL fr_done_pc got=%h exp=bfc00500", ftod_pc); end
  endtask

  task automatic test_misaligned();
    f_nextpc = 32'hBFC00600;
    #1;
    checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL mis_req got=%b exp=0", inst_req); end
    checks++; if (f_stall_req !== 1'b0) begin failures++; $display("FAIL mis_ready got=%b exp=0", f_stall_req); end
    step();
    checks++; if (ftod_addr_err_if !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", ftod_addr_err_if); end
    checks++; if (ftod_instr !== 32'h0) begin failures++; $display("FAIL mis_instr got=%h exp=0", ftod_instr); end
    checks++; if (ftod_pc !== 32'hBFC00002) begin failures++; $display("FAIL mis_pc got=%h exp=bfc00002", ftod_pc); end
    checks++; if (f_nowpc !== 32'hBFC00600) begin failures++; $display("FAIL mis_nextpc got=%h exp=bfc00600", f_nowpc); end
  endtask

  task automatic test_delay_slot();
    f_indelayslot = 1'b1; f_nextpc = 32'hBFC00604; inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0;
    step();
    inst_data_ok = 1'b0; f_indelayslot = 1'b0;
    checks++; if (ftod_in_delay_slot !== 1'b1) begin failures++; $display("FAIL ds_set got=%b exp=1", ftod_in_delay_slot); end
    checks++; if (ftod_addr_err_if !== 1'b0) begin failures++; $display("FAIL ds_err got=%b exp=0", ftod_addr_err_if); end
    checks++; if (ftod_pc !== 32'hBFC00600) begin failures++; $display("FAIL ds_pc got=%h exp=bfc00600", ftod_pc); end
    f_nextpc = 32'hBFC00608; inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h00851021;
    step();
    inst_data_ok = 1'b0;
    checks++; if (ftod_in_delay_slot !== 1'b0) begin failures++; $display("FAIL ds_clear got=%b exp=0", ftod_in_delay_slot); end
    checks++; if (ftod_pc !== 32'hBFC00604) begin failures++; $display("FAIL ds_pc2 got=%h exp=bfc00604", ftod_pc); end
  endtask

  task automatic test_reset_mid();
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0; rst = 1'b1;
    step();
    checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL rm_req got=%b exp=0", inst_req); end
    checks++; if (f_nowpc !== 32'hBFC00000) begin failures++; $display("FAIL rm_pc got=%h exp=bfc00000", f_nowpc); end
    checks++; if (ftod_is_instr !== 1'b0) begin failures++; $display("FAIL rm_is_instr got=%b exp=0", ftod_is_instr); end
    rst = 1'b0;
    #1;
    checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL rm_req2 got=%b exp=1", inst_req); end
    checks++; if (inst_addr !== 32'hBFC00000) begin failures++; $display("FAIL rm_addr got=%h exp=bfc00000", inst_addr); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall_return();
    test_flush_wait();
    test_flush_req();
    test_misaligned();
    test_delay_slot();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
